ahb3lite_mem_slave: RTL and testbench

Parametrised AHB-Lite memory-port slave with read and write support, and the successor to the team's write-only CPU/DMA slave. It sits between the AHB-Lite interconnect and a single-port synchronous memory. Features:
- Generic data width and address window.
- Programmable wait-state insertion.
- HSIZE-driven byte enables.
- Two-cycle ERROR response for out-of-window, oversized or misaligned transfers.

Pipelined back-to-back transfers are supported. BUSY is honoured inside bursts.

---
 rtl/ahb3lite_mem_slave.sv | 189 ++++++++++++++++++
 tb/tb_ahb3lite_mem_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_mem_slave.sv
// rtl/ahb3lite_mem_slave.sv - AHB-Lite slave bridging to a single-port synchronous memory
//
// Purpose: accepts AHB-Lite read/write transfers inside a fixed address window,
// inserts WAIT_STATES wait cycles per data phase, derives byte enables from
// HSIZE and returns a two-cycle ERROR for out-of-window, oversized or
// misaligned transfers.
//
// Ports:
//   HCLK, HRESET            bus clock, asynchronous active-high reset
//   HSEL, HADDR, HWRITE,    address-phase inputs
//   HSIZE, HBURST, HTRANS
//   HWDATA                  write data (data phase)
//   HREADY                  bus-wide ready
//   HREADYOUT, HRESP,       slave response
//   HRDATA
//   mem_addr                memory word address
//   mem_wr_en, mem_be,      memory write strobe, byte enables, write data
//   mem_wdata
//   mem_rd_en, mem_rdata    memory read strobe and read data (valid next cycle)
module ahb3lite_mem_slave #(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_BYTES   = 4096,
  parameter int          WAIT_STATES = 0,
  localparam int         BE_W        = DATA_W / 8,
  localparam int         BYTE_SH     = $clog2(BE_W),
  localparam int         ADDR_W      = $clog2(MEM_BYTES / BE_W)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rd_first_q, rd_first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;

  // Address-phase decode
  logic [32:0]       diff;
  logic              in_win;
  logic              size_err;
  logic [31:0]       align_mask;
  logic              misalign;
  logic              xfer_err;
  logic              accept;
  logic [7:0]        size_mask;
  logic [BE_W-1:0]   acc_be;
  logic              done;

  // HBURST carries no behaviour here
  logic unused_hburst;
  assign unused_hburst = ^HBURST;

  always_comb begin
    // 33-bit subtraction: a borrow in bit 32 means HADDR is below the window
    diff       = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    in_win     = !diff[32] && (diff[31:0] < 32'(MEM_BYTES));
    size_err   = (HSIZE > 3'(BYTE_SH));
    align_mask = (32'd1 << HSIZE) - 32'd1;
    misalign   = ((HADDR & align_mask) != 32'd0);
    xfer_err   = !in_win || size_err || misalign;
    accept     = HSEL && HREADY && HTRANS[1];
    case (HSIZE)
      3'd0:    size_mask = 8'h01;
      3'd1:    size_mask = 8'h03;
      3'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    acc_be = BE_W'(size_mask) << diff[BYTE_SH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_first_d = rd_first_q;
    addr_d     = addr_q;
    be_d       = be_q;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    HRDATA     = '0;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_be     = '0;
    mem_wdata  = '0;
    // done marks a cycle in which a new address phase may be taken
    done       = 1'b0;

    case (state_q)
      S_IDLE: done = 1'b1;
      S_WR: begin
        if (cnt_q != 3'd0) begin
          HREADYOUT = 1'b0;
          cnt_d     = cnt_q - 3'd1;
        end else begin
          mem_wr_en = 1'b1;
          mem_be    = be_q;
          mem_wdata = HWDATA;
          done      = 1'b1;
        end
      end
      S_RD: begin
        if (rd_first_q) begin
          mem_rd_en  = 1'b1;
          HREADYOUT  = 1'b0;
          rd_first_d = 1'b0;
        end else if (cnt_q != 3'd0) begin
          HREADYOUT = 1'b0;
          cnt_d     = cnt_q - 3'd1;
        end else begin
          HRDATA = mem_rdata;
          done   = 1'b1;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP = 1'b1;
        done  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion cycles double as the next address phase (back-to-back)
    if (done) begin
      state_d = S_IDLE;
      if (accept) begin
        if (xfer_err) begin
          state_d = S_ERR1;
        end else begin
          state_d    = HWRITE ? S_WR : S_RD;
          cnt_d      = WAIT_CNT;
          rd_first_d = !HWRITE;
          addr_d     = diff[BYTE_SH +: ADDR_W];
          be_d       = acc_be;
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      rd_first_q <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_first_q <= rd_first_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
    end
  end

  assign mem_addr = addr_q;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// tb/tb_ahb3lite_mem_slave.sv - directed self-checking bench for ahb3lite_mem_slave
module tb_ahb3lite_mem_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic        hclk;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  logic        hready;
  logic [1:0]  which;

  // instance 0: 32b WS0, 1: 32b WS2, 2: 32b WS3, 3: 64b WS0
  logic        hsel_i [4];
  logic        hro [4];
  logic        hrsp [4];
  logic        wen [4];
  logic        ren [4];
  logic [31:0] rd32 [3];
  logic [9:0]  ma32 [3];
  logic [3:0]  be32 [3];
  logic [31:0] wd32 [3];
  logic [63:0] rd64;
  logic [8:0]  ma64;
  logic [7:0]  be64;
  logic [63:0] wd64;
  logic [63:0] mrdata;

  logic        cur_hro, cur_rsp, cur_wen, cur_ren;
  logic [63:0] cur_rdata, cur_wdata;
  logic [15:0] cur_addr;
  logic [7:0]  cur_be;

  logic [63:0] mem [1024] = '{default: 64'h0};
  int          wr_cnt [4] = '{default: 0};
  int          rd_cnt [4] = '{default: 0};
  int          n_pass = 0, n_fail = 0, n_total = 0;

  ahb3lite_mem_slave #(.DATA_W(32), .BASE_ADDR(BASE), .MEM_BYTES(4096), .WAIT_STATES(0)) u_w0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel_i[0]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata[31:0]), .HREADY(hready),
    .HREADYOUT(hro[0]), .HRESP(hrsp[0]), .HRDATA(rd32[0]), .mem_addr(ma32[0]),
    .mem_wr_en(wen[0]), .mem_be(be32[0]), .mem_wdata(wd32[0]), .mem_rd_en(ren[0]),
    .mem_rdata(mrdata[31:0]));

  ahb3lite_mem_slave #(.DATA_W(32), .BASE_ADDR(BASE), .MEM_BYTES(4096), .WAIT_STATES(2)) u_w2 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel_i[1]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata[31:0]), .HREADY(hready),
    .HREADYOUT(hro[1]), .HRESP(hrsp[1]), .HRDATA(rd32[1]), .mem_addr(ma32[1]),
    .mem_wr_en(wen[1]), .mem_be(be32[1]), .mem_wdata(wd32[1]), .mem_rd_en(ren[1]),
    .mem_rdata(mrdata[31:0]));

  ahb3lite_mem_slave #(.DATA_W(32), .BASE_ADDR(BASE), .MEM_BYTES(4096), .WAIT_STATES(3)) u_w3 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel_i[2]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata[31:0]), .HREADY(hready),
    .HREADYOUT(hro[2]), .HRESP(hrsp[2]), .HRDATA(rd32[2]), .mem_addr(ma32[2]),
    .mem_wr_en(wen[2]), .mem_be(be32[2]), .mem_wdata(wd32[2]), .mem_rd_en(ren[2]),
    .mem_rdata(mrdata[31:0]));

  ahb3lite_mem_slave #(.DATA_W(64), .BASE_ADDR(BASE), .MEM_BYTES(4096), .WAIT_STATES(0)) u_d64 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel_i[3]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hro[3]), .HRESP(hrsp[3]), .HRDATA(rd64), .mem_addr(ma64),
    .mem_wr_en(wen[3]), .mem_be(be64), .mem_wdata(wd64), .mem_rd_en(ren[3]),
    .mem_rdata(mrdata));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  always_comb begin
    for (int k = 0; k < 4; k++) hsel_i[k] = hsel && (which == 2'(k));
    cur_hro = hro[which];
    cur_rsp = hrsp[which];
    cur_wen = wen[which];
    cur_ren = ren[which];
    case (which)
      2'd0: begin
        cur_rdata = {32'h0, rd32[0]}; cur_addr = {6'h0, ma32[0]};
        cur_be = {4'h0, be32[0]}; cur_wdata = {32'h0, wd32[0]};
      end
      2'd1: begin
        cur_rdata = {32'h0, rd32[1]}; cur_addr = {6'h0, ma32[1]};
        cur_be = {4'h0, be32[1]}; cur_wdata = {32'h0, wd32[1]};
      end
      2'd2: begin
        cur_rdata = {32'h0, rd32[2]}; cur_addr = {6'h0, ma32[2]};
        cur_be = {4'h0, be32[2]}; cur_wdata = {32'h0, wd32[2]};
      end
      default: begin
        cur_rdata = rd64; cur_addr = {7'h0, ma64};
        cur_be = be64; cur_wdata = wd64;
      end
    endcase
  end

  // single slave on the bus: bus-wide ready follows the selected slave
  assign hready = cur_hro;

  // byte-lane memory behind the selected slave
  always @(posedge hclk) begin
    if (cur_wen)
      for (int b = 0; b < 8; b++)
        if (cur_be[b]) mem[cur_addr[9:0]][8*b +: 8] <= cur_wdata[8*b +: 8];
    if (cur_ren) mrdata <= mem[cur_addr[9:0]];
    for (int k = 0; k < 4; k++) begin
      if (wen[k]) wr_cnt[k] <= wr_cnt[k] + 1;
      if (ren[k]) rd_cnt[k] <= rd_cnt[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [1:0] tr, input logic [63:0] wd);
    hsel = s; haddr = a; hwrite = w; hsize = sz; htrans = tr; hwdata = wd;
  endtask

  // one INCR4 beat on the WS2 slave: two wait cycles then the write strobe
  task automatic beat(input int b, input logic [1:0] ntr, input logic [31:0] na,
                      input logic [63:0] d);
    @(negedge hclk); drive(1'b1, na, 1'b1, 3'd2, ntr, d); #1;
    chk($sformatf("b%0d_wait1_hro", b), 64'(cur_hro), 64'd0);
    @(negedge hclk); #1;
    chk($sformatf("b%0d_wait2_hro", b), 64'(cur_hro), 64'd0);
    chk($sformatf("b%0d_wait2_wen", b), 64'(cur_wen), 64'd0);
    @(negedge hclk); #1;
    chk($sformatf("b%0d_wen", b), 64'(cur_wen), 64'd1);
    chk($sformatf("b%0d_addr", b), 64'(cur_addr), 64'(b));
    chk($sformatf("b%0d_wdata", b), cur_wdata, d);
    chk($sformatf("b%0d_hro", b), 64'(cur_hro), 64'd1);
  endtask

  logic [31:0] e_addr [3] = '{BASE + 32'd4096, BASE + 32'd1, BASE};
  logic [2:0]  e_size [3] = '{3'd2, 3'd1, 3'd3};
  logic        e_wr   [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    int w0_wr, w0_rd;
    hburst = 3'd0;
    which  = 2'd0;
    hreset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 3'd2, T_IDLE, 64'h0);
    @(negedge hclk); #1;
    chk("rst_hro", 64'(cur_hro), 64'd1);
    chk("rst_hresp", 64'(cur_rsp), 64'd0);
    chk("rst_hrdata", cur_rdata, 64'd0);
    @(negedge hclk); hreset = 1'b0;

    // reset in the middle of a WS3 write
    which = 2'd2;
    @(negedge hclk); drive(1'b1, BASE + 32'h20, 1'b1, 3'd2, T_NSEQ, 64'h0); #1;
    @(negedge hclk); drive(1'b1, BASE + 32'h20, 1'b0, 3'd2, T_IDLE, 64'h1111_2222); #1;
    chk("rwr_hro", 64'(cur_hro), 64'd0);
    chk("rwr_addr", 64'(cur_addr), 64'd8);
    @(negedge hclk); #1;
    hreset = 1'b1;
    #1;
    chk("rmid_hro", 64'(cur_hro), 64'd1);
    chk("rmid_hresp", 64'(cur_rsp), 64'd0);
    chk("rmid_wen", 64'(cur_wen), 64'd0);
    chk("rmid_ren", 64'(cur_ren), 64'd0);
    chk("rmid_be", 64'(cur_be), 64'd0);
    chk("rmid_addr", 64'(cur_addr), 64'd0);
    chk("rmid_wdata", cur_wdata, 64'd0);
    chk("rmid_hrdata", cur_rdata, 64'd0);
    @(negedge hclk); hreset = 1'b0;
    repeat (6) @(negedge hclk);
    chk("rst_no_wr", 64'(wr_cnt[2]), 64'd0);

    // single word write then read, WS0
    which = 2'd0;
    @(negedge hclk); drive(1'b1, BASE + 32'h10, 1'b1, 3'd2, T_NSEQ, 64'h0); #1;
    @(negedge hclk); drive(1'b1, BASE, 1'b0, 3'd2, T_IDLE, 64'hDEAD_BEEF); #1;
    chk("w_hro", 64'(cur_hro), 64'd1);
    chk("w_wen", 64'(cur_wen), 64'd1);
    chk("w_addr", 64'(cur_addr), 64'd4);
    chk("w_be", 64'(cur_be), 64'hF);
    chk("w_wdata", cur_wdata, 64'hDEAD_BEEF);
    @(negedge hclk); drive(1'b1, BASE + 32'h10, 1'b0, 3'd2, T_NSEQ, 64'h0); #1;
    chk("w_wen_once", 64'(cur_wen), 64'd0);
    chk("w_be_off", 64'(cur_be), 64'd0);
    @(negedge hclk); drive(1'b1, BASE, 1'b0, 3'd2, T_IDLE, 64'h0); #1;
    chk("r_first_hro", 64'(cur_hro), 64'd0);
    chk("r_first_ren", 64'(cur_ren), 64'd1);
    chk("r_first_hrdata", cur_rdata, 64'd0);
    @(negedge hclk); #1;
    chk("r_done_hro", 64'(cur_hro), 64'd1);
    chk("r_done_hrdata", cur_rdata, 64'hDEAD_BEEF);
    chk("r_done_ren", 64'(cur_ren), 64'd0);
    @(negedge hclk); #1;
    chk("r_after_hrdata", cur_rdata, 64'd0);

    // byte then halfword write back-to-back, then read the word
    @(negedge hclk); drive(1'b1, BASE + 32'h3, 1'b1, 3'd0, T_NSEQ, 64'h0); #1;
    @(negedge hclk); drive(1'b1, BASE + 32'h2, 1'b1, 3'd1, T_NSEQ, 64'hAA00_0000); #1;
    chk("byte_wen", 64'(cur_wen), 64'd1);
    chk("byte_be", 64'(cur_be), 64'h8);
    chk("byte_addr", 64'(cur_addr), 64'd0);
    @(negedge hclk); drive(1'b1, BASE, 1'b0, 3'd2, T_IDLE, 64'hBBCC_0000); #1;
    chk("half_wen", 64'(cur_wen), 64'd1);
    chk("half_be", 64'(cur_be), 64'hC);
    chk("half_wdata", cur_wdata, 64'hBBCC_0000);
    @(negedge hclk); drive(1'b1, BASE, 1'b0, 3'd2, T_NSEQ, 64'h0); #1;
    @(negedge hclk); drive(1'b1, BASE, 1'b0, 3'd2, T_IDLE, 64'h0); #1;
    chk("bh_ren", 64'(cur_ren), 64'd1);
    @(negedge hclk); #1;
    chk("bh_hrdata", cur_rdata, 64'hBBCC_0000);

    // error responses
    w0_wr = wr_cnt[0];
    w0_rd = rd_cnt[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk); drive(1'b1, e_addr[i], e_wr[i], e_size[i], T_NSEQ, 64'h0); #1;
      @(negedge hclk); drive(1'b1, BASE, 1'b0, 3'd2, T_IDLE, 64'h0); #1;
      chk($sformatf("err%0d_e1_hro", i), 64'(cur_hro), 64'd0);
      chk($sformatf("err%0d_e1_resp", i), 64'(cur_rsp), 64'd1);
      chk($sformatf("err%0d_e1_strobe", i), 64'(cur_wen | cur_ren), 64'd0);
      @(negedge hclk); #1;
      chk($sformatf("err%0d_e2_hro", i), 64'(cur_hro), 64'd1);
      chk($sformatf("err%0d_e2_resp", i), 64'(cur_rsp), 64'd1);
      chk($sformatf("err%0d_e2_strobe", i), 64'(cur_wen | cur_ren), 64'd0);
      @(negedge hclk); #1;
      chk($sformatf("err%0d_idle_resp", i), 64'(cur_rsp), 64'd0);
    end
    chk("err_no_wr", 64'(wr_cnt[0] - w0_wr), 64'd0);
    chk("err_no_rd", 64'(rd_cnt[0] - w0_rd), 64'd0);

    // INCR4 on WS2 with a BUSY between beats 2 and 3
    which = 2'd1;
    @(negedge hclk); drive(1'b1, BASE, 1'b1, 3'd2, T_NSEQ, 64'h0); #1;
    chk("incr_idle_hro", 64'(cur_hro), 64'd1);
    beat(0, T_SEQ, BASE + 32'h4, 64'hA0A0_0000);
    beat(1, T_BUSY, BASE + 32'h8, 64'hA1A1_1111);
    @(negedge hclk); drive(1'b1, BASE + 32'h8, 1'b1, 3'd2, T_SEQ, 64'h0); #1;
    chk("busy_hro", 64'(cur_hro), 64'd1);
    chk("busy_hresp", 64'(cur_rsp), 64'd0);
    chk("busy_wen", 64'(cur_wen), 64'd0);
    beat(2, T_SEQ, BASE + 32'hC, 64'hA2A2_2222);
    beat(3, T_IDLE, BASE + 32'hC, 64'hA3A3_3333);
    @(negedge hclk); drive(1'b0, BASE, 1'b0, 3'd2, T_IDLE, 64'h0); #1;
    chk("incr_wr_count", 64'(wr_cnt[1]), 64'd4);

    // 64-bit back-to-back write then read
    which = 2'd3;
    @(negedge hclk); drive(1'b1, BASE + 32'h18, 1'b1, 3'd3, T_NSEQ, 64'h0); #1;
    @(negedge hclk); drive(1'b1, BASE + 32'h18, 1'b0, 3'd3, T_NSEQ, 64'h0123_4567_89AB_CDEF); #1;
    chk("d64_wen", 64'(cur_wen), 64'd1);
    chk("d64_be", 64'(cur_be), 64'hFF);
    chk("d64_addr", 64'(cur_addr), 64'd3);
    chk("d64_wdata", cur_wdata, 64'h0123_4567_89AB_CDEF);
    @(negedge hclk); drive(1'b1, BASE, 1'b0, 3'd3, T_IDLE, 64'h0); #1;
    chk("d64_ren", 64'(cur_ren), 64'd1);
    chk("d64_rd_wen", 64'(cur_wen), 64'd0);
    chk("d64_rd_hro", 64'(cur_hro), 64'd0);
    @(negedge hclk); #1;
    chk("d64_hro", 64'(cur_hro), 64'd1);
    chk("d64_hrdata", cur_rdata, 64'h0123_4567_89AB_CDEF);
    @(negedge hclk); #1;
    chk("d64_hrdata_off", cur_rdata, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
